// File: rtl/fc3_sched_pkg.sv
// Shared types and helpers for the fc3 fold scheduler.
// State encoding, width helper and the perf-counter width used by
// fc3_fold_sched, fc3_sched_cnt and fc3_fold_sched_if.
package fc3_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of the stall-cycle performance counter.
    localparam int PERF_W = 16;

    // ceil(log2(v)), but never less than 1 so a 1-entry index still has a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fc3_fold_sched_if.sv
// Control/strobe bundle between the fc3 fold scheduler and its environment.
// The stallCnt member exists only when FC3_SCHED_PERF_EN is defined.
interface fc3_fold_sched_if #(
    parameter int FOLDW = 1,
    parameter int CYCW  = 1
);
    import fc3_sched_pkg::*;

    logic             start;
    logic             stall;
    logic             busy;
    logic             srcEn;
    logic [FOLDW-1:0] foldIdx;
    logic [CYCW-1:0]  cycIdx;
    logic             accClr;
    logic             accEn;
    logic             accDone;
    logic [FOLDW-1:0] capFold;
    logic             done;
`ifdef FC3_SCHED_PERF_EN
    logic [PERF_W-1:0] stallCnt;

    modport slave (
        input  start, stall,
        output busy, srcEn, foldIdx, cycIdx, accClr, accEn, accDone, capFold, done, stallCnt
    );
    modport master (
        output start, stall,
        input  busy, srcEn, foldIdx, cycIdx, accClr, accEn, accDone, capFold, done, stallCnt
    );
`else
    modport slave (
        input  start, stall,
        output busy, srcEn, foldIdx, cycIdx, accClr, accEn, accDone, capFold, done
    );
    modport master (
        output start, stall,
        input  busy, srcEn, foldIdx, cycIdx, accClr, accEn, accDone, capFold, done
    );
`endif

endinterface

// File: rtl/fc3_sched_cnt.sv
// Nested fold/cycle wrap counter. The cycle index runs 0..CYCLE-1; on its
// wrap the fold index advances, and after the very last step both return to 0.
module fc3_sched_cnt #(
    parameter int FOLD  = 1,
    parameter int CYCLE = 256,
    parameter int FOLDW = 1,
    parameter int CYCW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [FOLDW-1:0] fold_o,
    output logic [CYCW-1:0]  cyc_o,
    output logic             last_cyc_o,
    output logic             last_all_o
);

    logic [FOLDW-1:0] fold_q, fold_d;
    logic [CYCW-1:0]  cyc_q, cyc_d;
    logic             last_cyc_s;
    logic             last_fold_s;

    assign last_cyc_s  = (cyc_q == CYCW'(CYCLE - 1));
    assign last_fold_s = (fold_q == FOLDW'(FOLD - 1));

    // Next-count logic: clear wins, then step with nested wrap, else hold.
    always_comb begin
        cyc_d  = cyc_q;
        fold_d = fold_q;
        if (clr_i) begin
            cyc_d  = {CYCW{1'b0}};
            fold_d = {FOLDW{1'b0}};
        end else if (inc_i) begin
            if (last_cyc_s) begin
                cyc_d = {CYCW{1'b0}};
                if (last_fold_s) begin
                    fold_d = {FOLDW{1'b0}};
                end else begin
                    fold_d = fold_q + FOLDW'(1);
                end
            end else begin
                cyc_d = cyc_q + CYCW'(1);
            end
        end else begin
            cyc_d  = cyc_q;
            fold_d = fold_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= {CYCW{1'b0}};
            fold_q <= {FOLDW{1'b0}};
        end else begin
            cyc_q  <= cyc_d;
            fold_q <= fold_d;
        end
    end

    assign fold_o     = fold_q;
    assign cyc_o      = cyc_q;
    assign last_cyc_o = last_cyc_s;
    assign last_all_o = last_cyc_s & last_fold_s;

endmodule

// File: rtl/fc3_fold_sched.sv
// Sequencing controller for the folded fc3 multiply stage.
// Runs FOLD passes of CYCLE bitstream cycles, advancing the sources with
// srcEn and issuing accumulator strobes one cycle later to line up with the
// multiplier's registered output.
// Optional macro FC3_SCHED_PERF_EN adds a saturating 16-bit stall counter.
module fc3_fold_sched
    import fc3_sched_pkg::*;
#(
    parameter int IDIM  = 1,
    parameter int ODIM  = 1,
    parameter int FOLD  = 1,
    parameter int CYCLE = 256,
    parameter int FOLDW = clog2_min1(FOLD),
    parameter int CYCW  = clog2_min1(CYCLE)
) (
    input  logic           clk,
    input  logic           rst,
    fc3_fold_sched_if.slave bus
);

    // Reject configurations that cannot be sequenced.
    if ((FOLD < 1) || (CYCLE < 1) || (IDIM < 1) || ((ODIM % FOLD) != 0)) begin : g_bad_cfg
        $error("fc3_fold_sched: invalid IDIM/ODIM/FOLD/CYCLE configuration");
    end

    state_e           state_q, state_d;
    logic             src_en_s;
    logic             cnt_clr_s;
    logic             in_run_s;
    logic [FOLDW-1:0] fold_s;
    logic [CYCW-1:0]  cyc_s;
    logic             last_cyc_s;
    logic             last_all_s;

    logic             busy_q;
    logic             done_q;
    logic             acc_en_q;
    logic             acc_clr_q;
    logic             acc_done_q;
    logic [FOLDW-1:0] cap_fold_q;

    fc3_sched_cnt #(
        .FOLD  (FOLD),
        .CYCLE (CYCLE),
        .FOLDW (FOLDW),
        .CYCW  (CYCW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr_s),
        .inc_i      (src_en_s),
        .fold_o     (fold_s),
        .cyc_o      (cyc_s),
        .last_cyc_o (last_cyc_s),
        .last_all_o (last_all_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start is only honoured in IDLE; RUN ends on the last advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (src_en_s && last_all_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: source advance is combinational so a stall takes effect immediately.
    always_comb begin
        in_run_s  = 1'b0;
        src_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr_s = bus.start;
            end
            ST_RUN: begin
                in_run_s = 1'b1;
                src_en_s = ~bus.stall;
            end
            ST_DRAIN: begin
                src_en_s = 1'b0;
            end
            ST_DONE: begin
                src_en_s = 1'b0;
            end
            default: begin
                src_en_s = 1'b0;
            end
        endcase
    end

    // Strobe pipeline delayed one cycle to match the multiplier, plus registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_done_q <= 1'b0;
            cap_fold_q <= {FOLDW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            acc_en_q   <= src_en_s;
            acc_clr_q  <= src_en_s && (cyc_s == {CYCW{1'b0}});
            acc_done_q <= src_en_s && last_cyc_s;
            cap_fold_q <= fold_s;
            busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q     <= (state_d == ST_DONE);
        end
    end

`ifdef FC3_SCHED_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;

    // Stall-cycle counter: cleared on an accepted start, saturates, holds after the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {PERF_W{1'b0}};
        end else if (cnt_clr_s) begin
            stall_cnt_q <= {PERF_W{1'b0}};
        end else if (in_run_s && bus.stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign bus.stallCnt = stall_cnt_q;
`endif

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.srcEn   = src_en_s;
    assign bus.foldIdx = in_run_s ? fold_s : {FOLDW{1'b0}};
    assign bus.cycIdx  = in_run_s ? cyc_s : {CYCW{1'b0}};
    assign bus.accEn   = acc_en_q;
    assign bus.accClr  = acc_clr_q;
    assign bus.accDone = acc_done_q;
    assign bus.capFold = cap_fold_q;

endmodule

// File: tb/tb_fc3_fold_sched.sv
// Directed-vector bench for fc3_fold_sched. Two instances: A (FOLD=2,
// CYCLE=4) and B (FOLD=1, CYCLE=1). Each scenario is a per-cycle table;
// bit masks read left to right as cycle 0,1,2,... (cycle t = bit 31-t),
// cycle-index tables are one hex nibble per cycle, also left to right.
module tb_fc3_fold_sched;
    import fc3_sched_pkg::*;

    localparam int FW_A = clog2_min1(2);
    localparam int CW_A = clog2_min1(4);
    localparam int FW_B = clog2_min1(1);
    localparam int CW_B = clog2_min1(1);

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fc3_fold_sched_if #(.FOLDW(FW_A), .CYCW(CW_A)) if_a ();
    fc3_fold_sched_if #(.FOLDW(FW_B), .CYCW(CW_B)) if_b ();

    fc3_fold_sched #(.IDIM(1), .ODIM(2), .FOLD(2), .CYCLE(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    fc3_fold_sched #(.IDIM(1), .ODIM(1), .FOLD(1), .CYCLE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        if_a.start = 1'b0;
        if_a.stall = 1'b0;
        if_b.start = 1'b0;
        if_b.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Apply one scenario table to instance sel (0=A, 1=B) and check every cycle.
    task automatic run_vec(input string name, input bit sel, input int n,
                           input logic [31:0] st_m, input logic [31:0] sl_m,
                           input logic [31:0] rs_m,
                           input logic [31:0] e_busy, input logic [31:0] e_src,
                           input logic [31:0] e_fold, input logic [31:0] e_en,
                           input logic [31:0] e_clr, input logic [31:0] e_dn,
                           input logic [31:0] e_cap, input logic [31:0] e_done,
                           input logic [127:0] e_cyc);
        logic [31:0] o_busy, o_src, o_fold, o_cyc, o_en, o_clr, o_dn, o_cap, o_done;
        for (int t = 0; t < n; t++) begin
            rst = rs_m[31-t];
            if (sel == 1'b0) begin
                if_a.start = st_m[31-t];
                if_a.stall = sl_m[31-t];
            end else begin
                if_b.start = st_m[31-t];
                if_b.stall = sl_m[31-t];
            end
            @(negedge clk);
            if (sel == 1'b0) begin
                o_busy = 32'(if_a.busy);    o_src = 32'(if_a.srcEn);
                o_fold = 32'(if_a.foldIdx); o_cyc = 32'(if_a.cycIdx);
                o_en   = 32'(if_a.accEn);   o_clr = 32'(if_a.accClr);
                o_dn   = 32'(if_a.accDone); o_cap = 32'(if_a.capFold);
                o_done = 32'(if_a.done);
            end else begin
                o_busy = 32'(if_b.busy);    o_src = 32'(if_b.srcEn);
                o_fold = 32'(if_b.foldIdx); o_cyc = 32'(if_b.cycIdx);
                o_en   = 32'(if_b.accEn);   o_clr = 32'(if_b.accClr);
                o_dn   = 32'(if_b.accDone); o_cap = 32'(if_b.capFold);
                o_done = 32'(if_b.done);
            end
            check_eq($sformatf("%s.busy@%0d", name, t),    o_busy, 32'(e_busy[31-t]));
            check_eq($sformatf("%s.srcEn@%0d", name, t),   o_src,  32'(e_src[31-t]));
            check_eq($sformatf("%s.foldIdx@%0d", name, t), o_fold, 32'(e_fold[31-t]));
            check_eq($sformatf("%s.cycIdx@%0d", name, t),  o_cyc,  32'(e_cyc[127-4*t -: 4]));
            check_eq($sformatf("%s.accEn@%0d", name, t),   o_en,   32'(e_en[31-t]));
            check_eq($sformatf("%s.accClr@%0d", name, t),  o_clr,  32'(e_clr[31-t]));
            check_eq($sformatf("%s.accDone@%0d", name, t), o_dn,   32'(e_dn[31-t]));
            check_eq($sformatf("%s.capFold@%0d", name, t), o_cap,  32'(e_cap[31-t]));
            check_eq($sformatf("%s.done@%0d", name, t),    o_done, 32'(e_done[31-t]));
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        if_a.start = 1'b0;
        if_a.stall = 1'b0;
        if_b.start = 1'b0;
        if_b.stall = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // S1: plain run; stall at 11,12 falls in IDLE and must not matter.
        do_reset();
        run_vec("s1_basic", 1'b0, 13,
                32'b1000_0000_0000_0000_0000_0000_0000_0000,   // start
                32'b0000_0000_0001_1000_0000_0000_0000_0000,   // stall
                32'b0000_0000_0000_0000_0000_0000_0000_0000,   // rst
                32'b0111_1111_1100_0000_0000_0000_0000_0000,   // busy
                32'b0111_1111_1000_0000_0000_0000_0000_0000,   // srcEn
                32'b0000_0111_1000_0000_0000_0000_0000_0000,   // foldIdx
                32'b0011_1111_1100_0000_0000_0000_0000_0000,   // accEn
                32'b0010_0010_0000_0000_0000_0000_0000_0000,   // accClr
                32'b0000_0100_0100_0000_0000_0000_0000_0000,   // accDone
                32'b0000_0011_1100_0000_0000_0000_0000_0000,   // capFold
                32'b0000_0000_0010_0000_0000_0000_0000_0000,   // done
                128'h0012_3012_3000_0000_0000_0000_0000_0000); // cycIdx
`ifdef FC3_SCHED_PERF_EN
        check_eq("s1_basic.stallCnt", 32'(if_a.stallCnt), 32'd0);
`endif

        // S2: stall during RUN at cycles 3 and 4.
        do_reset();
        run_vec("s2_stall", 1'b0, 14,
                32'b1000_0000_0000_0000_0000_0000_0000_0000,
                32'b0001_1000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0111_1111_1111_0000_0000_0000_0000_0000,
                32'b0110_0111_1110_0000_0000_0000_0000_0000,
                32'b0000_0001_1110_0000_0000_0000_0000_0000,
                32'b0011_0011_1111_0000_0000_0000_0000_0000,
                32'b0010_0000_1000_0000_0000_0000_0000_0000,
                32'b0000_0001_0001_0000_0000_0000_0000_0000,
                32'b0000_0000_1111_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_1000_0000_0000_0000_0000,
                128'h0012_2230_1230_0000_0000_0000_0000_0000);
`ifdef FC3_SCHED_PERF_EN
        check_eq("s2_stall.stallCnt", 32'(if_a.stallCnt), 32'd2);
`endif

        // S3: second start during RUN is ignored.
        do_reset();
        run_vec("s3_restart", 1'b0, 13,
                32'b1000_1000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0111_1111_1100_0000_0000_0000_0000_0000,
                32'b0111_1111_1000_0000_0000_0000_0000_0000,
                32'b0000_0111_1000_0000_0000_0000_0000_0000,
                32'b0011_1111_1100_0000_0000_0000_0000_0000,
                32'b0010_0010_0000_0000_0000_0000_0000_0000,
                32'b0000_0100_0100_0000_0000_0000_0000_0000,
                32'b0000_0011_1100_0000_0000_0000_0000_0000,
                32'b0000_0000_0010_0000_0000_0000_0000_0000,
                128'h0012_3012_3000_0000_0000_0000_0000_0000);

        // S4: reset at cycle 5 aborts the run; new start at 7 completes at 17.
        do_reset();
        run_vec("s4_abort", 1'b0, 19,
                32'b1000_0001_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0100_0000_0000_0000_0000_0000_0000,
                32'b0111_1100_1111_1111_1000_0000_0000_0000,
                32'b0111_1100_1111_1111_0000_0000_0000_0000,
                32'b0000_0100_0000_1111_0000_0000_0000_0000,
                32'b0011_1100_0111_1111_1000_0000_0000_0000,
                32'b0010_0000_0100_0100_0000_0000_0000_0000,
                32'b0000_0100_0000_1000_1000_0000_0000_0000,
                32'b0000_0000_0000_0111_1000_0000_0000_0000,
                32'b0000_0000_0000_0000_0100_0000_0000_0000,
                128'h0012_3000_0123_0123_0000_0000_0000_0000);
`ifdef FC3_SCHED_PERF_EN
        check_eq("s4_abort.stallCnt", 32'(if_a.stallCnt), 32'd0);
`endif

        // S5: FOLD=1, CYCLE=1 degenerate pass; clr/en/done coincide.
        do_reset();
        run_vec("s5_min", 1'b1, 5,
                32'b1000_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0110_0000_0000_0000_0000_0000_0000_0000,
                32'b0100_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0010_0000_0000_0000_0000_0000_0000_0000,
                32'b0010_0000_0000_0000_0000_0000_0000_0000,
                32'b0010_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0001_0000_0000_0000_0000_0000_0000_0000,
                128'h0000_0000_0000_0000_0000_0000_0000_0000);

        // S6: start held high; ignored in DONE, next run accepted from IDLE at 11.
        do_reset();
        run_vec("s6_held", 1'b0, 14,
                32'b1111_1111_1111_1100_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0000_0000_0000_0000_0000_0000_0000_0000,
                32'b0111_1111_1100_1100_0000_0000_0000_0000,
                32'b0111_1111_1000_1100_0000_0000_0000_0000,
                32'b0000_0111_1000_0000_0000_0000_0000_0000,
                32'b0011_1111_1100_0100_0000_0000_0000_0000,
                32'b0010_0010_0000_0100_0000_0000_0000_0000,
                32'b0000_0100_0100_0000_0000_0000_0000_0000,
                32'b0000_0011_1100_0000_0000_0000_0000_0000,
                32'b0000_0000_0010_0000_0000_0000_0000_0000,
                128'h0012_3012_3000_0100_0000_0000_0000_0000);

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
